cd_frame_fifo: RTL and testbench

CD_FRAME_FIFO -- requirements
Module: cd_frame_fifo

---
 rtl/cd_frame_fifo.sv | 154 +++++++++++++++
 tb/tb_cd_frame_fifo.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cd_frame_fifo.sv
// Frame FIFO: N_FRAMES slots of 2^A_WIDTH bytes, each with a flag byte latched on commit.
// Define CD_FRAME_FIFO_OVERWRITE_EN to let a commit into a full FIFO drop the oldest frame.
module cd_frame_fifo #(
    parameter int N_FRAMES    = 8,
    parameter int A_WIDTH     = 8,
    parameter int C_ASIC_SRAM = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [7:0]                    wr_byte,
    input  logic [A_WIDTH-1:0]            wr_addr,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_flags,
    input  logic                          commit,
    output logic                          commit_fail,
    input  logic [A_WIDTH-1:0]            rd_addr,
    input  logic                          rd_en,
    output logic [7:0]                    rd_byte,
    output logic [7:0]                    rd_flags,
    input  logic                          rd_done,
    input  logic                          rd_done_all,
    output logic                          unread,
    output logic [$clog2(N_FRAMES):0]     count
);

    localparam int PW    = $clog2(N_FRAMES);
    localparam int CW    = PW + 1;
    localparam int DEPTH = N_FRAMES << A_WIDTH;

    logic [PW-1:0]         r_wp;
    logic [PW-1:0]         r_rp;
    logic [CW-1:0]         r_count;
    logic                  r_commit_fail;
    logic [7:0]            r_rd_byte;
    logic [7:0]            r_flags [N_FRAMES];

    logic [PW-1:0]         w_wp_d;
    logic [PW-1:0]         w_rp_d;
    logic [CW-1:0]         w_count_d;
    logic                  w_fail_d;
    logic                  w_flag_we;
    logic                  w_full;
    logic                  w_rd_ok;
    logic                  w_commit_ok;
    logic [PW+A_WIDTH-1:0] w_wr_idx;
    logic [PW+A_WIDTH-1:0] w_rd_idx;
    logic [7:0]            w_ram_q;

    assign w_full      = (r_count == CW'(N_FRAMES));
    assign w_rd_ok     = rd_done && (r_count != '0);
    // A release in the same cycle frees the slot the commit needs.
    assign w_commit_ok = commit && (!w_full || w_rd_ok);
    assign w_wr_idx    = {r_wp, wr_addr};
    assign w_rd_idx    = {r_rp, rd_addr};

    always_comb begin
        w_wp_d    = r_wp;
        w_rp_d    = r_rp;
        w_count_d = r_count;
        w_fail_d  = 1'b0;
        w_flag_we = 1'b0;
        if (rd_done_all) begin
            w_rp_d    = r_wp;
            w_count_d = '0;
            if (commit) begin
                w_flag_we = 1'b1;
                w_wp_d    = r_wp + 1'b1;
                w_count_d = CW'(1);
            end
        end else begin
            if (w_commit_ok) begin
                w_flag_we = 1'b1;
                w_wp_d    = r_wp + 1'b1;
            end
`ifdef CD_FRAME_FIFO_OVERWRITE_EN
            else if (commit) begin
                // Full and no release: sacrifice the oldest frame, count stays at N_FRAMES.
                w_flag_we = 1'b1;
                w_wp_d    = r_wp + 1'b1;
                w_rp_d    = r_rp + 1'b1;
                w_fail_d  = 1'b1;
            end
`else
            else if (commit) begin
                w_fail_d = 1'b1;
            end
`endif
            if (w_rd_ok) begin
                w_rp_d = r_rp + 1'b1;
            end
            if (w_commit_ok && !w_rd_ok) begin
                w_count_d = r_count + 1'b1;
            end else if (!w_commit_ok && w_rd_ok) begin
                w_count_d = r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wp          <= '0;
            r_rp          <= '0;
            r_count       <= '0;
            r_commit_fail <= 1'b0;
            for (int i = 0; i < N_FRAMES; i++) begin
                r_flags[i] <= '0;
            end
        end else begin
            r_wp          <= w_wp_d;
            r_rp          <= w_rp_d;
            r_count       <= w_count_d;
            r_commit_fail <= w_fail_d;
            if (w_flag_we) begin
                r_flags[r_wp] <= wr_flags;
            end
        end
    end

    // Payload storage is never reset; both variants share one write/read timing.
    generate
        if (C_ASIC_SRAM != 0) begin : g_sram
            logic [7:0] r_sram [DEPTH];
            always_ff @(posedge clk) begin
                if (wr_en) begin
                    r_sram[w_wr_idx] <= wr_byte;
                end
            end
            assign w_ram_q = r_sram[w_rd_idx];
        end else begin : g_flop
            logic [7:0] r_mem [DEPTH];
            always_ff @(posedge clk) begin
                if (wr_en) begin
                    r_mem[w_wr_idx] <= wr_byte;
                end
            end
            assign w_ram_q = r_mem[w_rd_idx];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_byte <= '0;
        end else if (rd_en) begin
            r_rd_byte <= w_ram_q;
        end
    end

    assign commit_fail = r_commit_fail;
    assign rd_byte     = r_rd_byte;
    assign rd_flags    = r_flags[r_rp];
    assign count       = r_count;
    assign unread      = (r_count != '0);

endmodule

// File: tb/tb_cd_frame_fifo.sv
// Directed bench for cd_frame_fifo at N_FRAMES=4, A_WIDTH=4; expectations follow
// CD_FRAME_FIFO_OVERWRITE_EN where the two builds differ.
module tb_cd_frame_fifo;

    localparam int NF = 4;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [7:0]    wr_byte;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic [7:0]    wr_flags;
    logic          commit;
    logic          commit_fail;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [7:0]    rd_byte;
    logic [7:0]    rd_flags;
    logic          rd_done;
    logic          rd_done_all;
    logic          unread;
    logic [2:0]    count;

    int n_checks = 0;
    int n_fail   = 0;

    cd_frame_fifo #(
        .N_FRAMES    (NF),
        .A_WIDTH     (AW),
        .C_ASIC_SRAM (0)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_byte     (wr_byte),
        .wr_addr     (wr_addr),
        .wr_en       (wr_en),
        .wr_flags    (wr_flags),
        .commit      (commit),
        .commit_fail (commit_fail),
        .rd_addr     (rd_addr),
        .rd_en       (rd_en),
        .rd_byte     (rd_byte),
        .rd_flags    (rd_flags),
        .rd_done     (rd_done),
        .rd_done_all (rd_done_all),
        .unread      (unread),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en       = 1'b0;
        commit      = 1'b0;
        rd_en       = 1'b0;
        rd_done     = 1'b0;
        rd_done_all = 1'b0;
    endtask

    task automatic commit_frame(input logic [7:0] flags);
        commit   = 1'b1;
        wr_flags = flags;
        step();
        idle();
    endtask

    initial begin
        reset_n  = 1'b0;
        wr_byte  = '0;
        wr_addr  = '0;
        wr_flags = '0;
        rd_addr  = '0;
        idle();
        #3;
        chk("reset_count", 32'(count), 0);
        chk("reset_unread", 32'(unread), 0);
        chk("reset_rd_flags", 32'(rd_flags), 0);
        chk("reset_rd_byte", 32'(rd_byte), 0);
        chk("reset_commit_fail", 32'(commit_fail), 0);
        #9 reset_n = 1'b1;
        step();

        // Fill slot 0 and commit it.
        for (int i = 0; i < 15; i++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_byte = 8'(8'h11 + i);
            step();
        end
        idle();
        commit_frame(8'hA5);
        chk("first_count", 32'(count), 1);
        chk("first_unread", 32'(unread), 1);
        chk("first_rd_flags", 32'(rd_flags), 32'hA5);
        rd_en   = 1'b1;
        rd_addr = 4'd3;
        step();
        idle();
        chk("read_addr3", 32'(rd_byte), 32'h14);
        rd_addr = 4'd5;
        step();
        chk("rd_byte_hold", 32'(rd_byte), 32'h14);
        rd_done = 1'b1;
        step();
        idle();
        chk("release_count", 32'(count), 0);
        chk("release_unread", 32'(unread), 0);

        // Fill to capacity (slots 1,2,3,0), then one more.
        for (int i = 0; i < 4; i++) begin
            commit_frame(8'(8'hB0 + i));
        end
        chk("full_count", 32'(count), 4);
        chk("full_rd_flags", 32'(rd_flags), 32'hB0);
        chk("full_no_fail", 32'(commit_fail), 0);
        commit_frame(8'hB4);
        chk("overflow_fail", 32'(commit_fail), 1);
        chk("overflow_count", 32'(count), 4);
`ifdef CD_FRAME_FIFO_OVERWRITE_EN
        chk("overflow_rd_flags", 32'(rd_flags), 32'hB1);
`else
        chk("overflow_rd_flags", 32'(rd_flags), 32'hB0);
`endif
        step();
        chk("fail_one_cycle", 32'(commit_fail), 0);

        // Commit and release together while full.
        commit   = 1'b1;
        rd_done  = 1'b1;
        wr_flags = 8'hC0;
        step();
        idle();
        chk("full_pair_fail", 32'(commit_fail), 0);
        chk("full_pair_count", 32'(count), 4);
`ifdef CD_FRAME_FIFO_OVERWRITE_EN
        chk("full_pair_rd_flags", 32'(rd_flags), 32'hB2);
`else
        chk("full_pair_rd_flags", 32'(rd_flags), 32'hB1);
`endif
        rd_done_all = 1'b1;
        step();
        idle();
        chk("done_all_count", 32'(count), 0);
        chk("done_all_unread", 32'(unread), 0);

        // Ten commit/release pairs wrap both pointers.
        for (int i = 0; i < 10; i++) begin
            commit_frame(8'(i));
            chk("pair_rd_flags", 32'(rd_flags), 32'(i));
            chk("pair_count_up", 32'(count), 1);
            rd_done = 1'b1;
            step();
            idle();
            chk("pair_count_down", 32'(count), 0);
        end

        // Release on an empty FIFO must not move rp.
        rd_done = 1'b1;
        step();
        idle();
        chk("empty_done_count", 32'(count), 0);
        commit_frame(8'h77);
        chk("empty_done_rp", 32'(rd_flags), 32'h77);
        chk("empty_done_count1", 32'(count), 1);
        rd_done = 1'b1;
        step();
        idle();

        // Release-all combined with commit and release.
        commit_frame(8'hD0);
        commit_frame(8'hD1);
        commit_frame(8'hD2);
        chk("three_count", 32'(count), 3);
        rd_done_all = 1'b1;
        rd_done     = 1'b1;
        commit      = 1'b1;
        wr_flags    = 8'hE5;
        step();
        idle();
        chk("all_commit_count", 32'(count), 1);
        chk("all_commit_rd_flags", 32'(rd_flags), 32'hE5);
        chk("all_commit_fail", 32'(commit_fail), 0);
        rd_done = 1'b1;
        step();
        idle();

        // Write in the commit cycle lands in the frame being closed.
        wr_en    = 1'b1;
        wr_addr  = 4'd7;
        wr_byte  = 8'h5A;
        commit   = 1'b1;
        wr_flags = 8'h21;
        step();
        idle();
        commit_frame(8'h22);
        chk("two_count", 32'(count), 2);
        chk("two_rd_flags", 32'(rd_flags), 32'h21);
        rd_en   = 1'b1;
        rd_addr = 4'd7;
        step();
        idle();
        chk("same_cycle_write", 32'(rd_byte), 32'h5A);

        // Asynchronous reset mid-cycle.
        #1 reset_n = 1'b0;
        #1;
        chk("async_count", 32'(count), 0);
        chk("async_unread", 32'(unread), 0);
        chk("async_rd_byte", 32'(rd_byte), 0);
        chk("async_rd_flags", 32'(rd_flags), 0);
        #1 reset_n = 1'b1;
        step();
        chk("post_reset_count", 32'(count), 0);

        // RAM survives reset: slot 0 still holds the first frame.
        rd_en   = 1'b1;
        rd_addr = 4'd3;
        step();
        idle();
        chk("ram_kept", 32'(rd_byte), 32'h14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
